// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t   : loader FSM states
//   ERR_*     : err_code encodings reported while in ERROR
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // Word index to word-aligned byte address.
    function automatic logic [17:0] word_to_byte_addr(input logic [15:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian word assembler with running XOR checksum.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   clear       : zero lane index, partial word and checksum
//   en          : accept data into lane byte_idx
//   data        : incoming byte
//   word        : partial word with the current byte already merged into its lane
//   chk         : XOR of every byte accepted since the last clear
//   word_ready  : en is completing lane 3 this cycle (word is whole)
module word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [7:0]  chk,
    output logic        word_ready
);

    logic [31:0] word_q;
    logic [1:0]  byte_idx;
    logic [7:0]  chk_q;

    // Merge combinationally so the caller can register the completed word
    // on the same edge that accepts the last byte.
    always_comb begin
        word                   = word_q;
        word[8*byte_idx +: 8]  = data;
    end

    assign chk        = chk_q;
    assign word_ready = en && (byte_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q   <= 32'h0;
            byte_idx <= 2'd0;
            chk_q    <= 8'h0;
        end else if (en) begin
            word_q   <= word;
            byte_idx <= byte_idx + 2'd1;
            chk_q    <= chk_q ^ data;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a UART byte frame (MAGIC, LEN_LO, LEN_HI, LEN words LSB
// first, XOR checksum), writes the words into instruction memory from address 0
// and releases the core reset only after a frame with a good checksum.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   reload              : re-arm from DONE or ERROR
//   imem_we/addr/wdata  : instruction memory write port (registered)
//   core_rst_n          : active-low core reset, high only in DONE
//   load_done, load_err : status flags for DONE / ERROR
//   err_code            : reason for ERROR (ERR_* in boot_pkg)
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [15:0]      word_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic        in_frame;
    logic        tmo_hit;
    logic [15:0] rx_len;
    logic        asm_clear;
    logic        asm_en;
    logic        word_ready;
    logic [31:0] asm_word;
    logic [7:0]  asm_chk;

    assign in_frame  = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CHECK);
    assign rx_len    = {rx_data, len_lo};
    // A byte arriving on the expiry cycle wins, hence the !rx_valid term.
    assign tmo_hit   = in_frame && !rx_valid && (32'(tmo_cnt) == TIMEOUT_CYC - 1);
    assign asm_clear = (state == LEN_HI) && rx_valid;
    assign asm_en    = (state == DATA) && rx_valid;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .en         (asm_en),
        .data       (rx_data),
        .word       (asm_word),
        .chk        (asm_chk),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_lo     <= 8'h0;
            len        <= 16'h0;
            word_cnt   <= 16'h0;
            tmo_cnt    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            imem_we <= 1'b0;

            if (word_ready) begin
                imem_we    <= 1'b1;
                imem_addr  <= ADDR_W'(word_to_byte_addr(word_cnt));
                imem_wdata <= asm_word;
                word_cnt   <= word_cnt + 16'd1;
            end

            if (!in_frame || rx_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == MAGIC) state <= LEN_LO;
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        len_lo <= rx_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (rx_valid) begin
                        len      <= rx_len;
                        word_cnt <= 16'h0;
                        if (32'(rx_len) > MAX_WORDS) begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                            err_code <= ERR_LEN;
                        end else if (rx_len == 16'h0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_ready && word_cnt == len - 16'd1) state <= CHECK;
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == asm_chk) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                            err_code <= ERR_CHK;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state      <= IDLE;
                        load_done  <= 1'b0;
                        core_rst_n <= 1'b0;
                    end
                end
                ERROR: begin
                    if (reload) begin
                        state    <= IDLE;
                        load_err <= 1'b0;
                        err_code <= ERR_NONE;
                    end else if (rx_valid && rx_data == MAGIC) begin
                        state    <= LEN_LO;
                        load_err <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Timeout only fires on idle cycles, so it never races a byte-driven transition.
            if (tmo_hit) begin
                state    <= ERROR;
                load_err <= 1'b1;
                err_code <= ERR_TMO;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frame-level reference model compared
// against the DUT outputs after every clock, plus directed literal checks.
module tb_imem_boot_loader;

    localparam int unsigned TMO  = 40;
    localparam int unsigned MAXW = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    imem_boot_loader #(
        .MAGIC       (8'hA5),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TMO),
        .ADDR_W      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 waiting for MAGIC, 1 inside frame, 2 loaded, 3 failed.
    // m_pos counts frame bytes received after MAGIC.
    int          m_mode = 0;
    int          m_pos  = 0;
    int          m_len  = 0;
    int          m_idle = 0;
    int          m_k    = 0;
    logic [7:0]  m_lo   = 8'h0;
    logic [7:0]  m_chk  = 8'h0;
    logic [31:0] m_word = 32'h0;
    logic        exp_we = 1'b0, exp_crn = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [1:0]  exp_code = 2'b00;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];

    logic [7:0] fr[$];

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pos = 0; m_len = 0; m_idle = 0; m_chk = 8'h0;
            exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_crn = 0;
            exp_done = 0; exp_err = 0; exp_code = 2'b00;
        end else begin
            exp_we = 1'b0;
            case (m_mode)
                0: if (rx_valid && rx_data == 8'hA5) begin
                    m_mode = 1; m_pos = 0; m_idle = 0;
                end
                1: if (rx_valid) begin
                    m_idle = 0;
                    if (m_pos == 0) begin
                        m_lo = rx_data;
                    end else if (m_pos == 1) begin
                        m_len = {rx_data, m_lo};
                        m_chk = 8'h0;
                        if (m_len > MAXW) begin
                            m_mode = 3; exp_err = 1; exp_code = 2'b10;
                        end
                    end else if (m_pos < 2 + 4 * m_len) begin
                        m_k = m_pos - 2;
                        m_chk ^= rx_data;
                        m_word[8*(m_k%4) +: 8] = rx_data;
                        if (m_k % 4 == 3) begin
                            exp_we = 1; exp_addr = 32'((m_k / 4) * 4); exp_wdata = m_word;
                        end
                    end else if (rx_data == m_chk) begin
                        m_mode = 2; exp_done = 1; exp_crn = 1;
                    end else begin
                        m_mode = 3; exp_err = 1; exp_code = 2'b01;
                    end
                    m_pos++;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_mode = 3; exp_err = 1; exp_code = 2'b11;
                    end
                end
                2: if (reload) begin
                    m_mode = 0; exp_done = 0; exp_crn = 0;
                end
                3: if (reload) begin
                    m_mode = 0; exp_err = 0; exp_code = 2'b00;
                end else if (rx_valid && rx_data == 8'hA5) begin
                    m_mode = 1; m_pos = 0; m_idle = 0; exp_err = 0; exp_code = 2'b00;
                end
                default: m_mode = 0;
            endcase
        end
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, core_rst_n, load_done, load_err, err_code} !==
            {exp_we, exp_addr, exp_wdata, exp_crn, exp_done, exp_err, exp_code}) begin
            errors++;
            $display("FAIL outputs t=%0t actual we=%b addr=%h wdata=%h crn=%b done=%b err=%b code=%b required we=%b addr=%h wdata=%h crn=%b done=%b err=%b code=%b",
                     $time, imem_we, imem_addr, imem_wdata, core_rst_n, load_done, load_err,
                     err_code, exp_we, exp_addr, exp_wdata, exp_crn, exp_done, exp_err, exp_code);
        end
        if (imem_we === 1'b1) wlog.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_fr(input int maxgap);
        foreach (fr[i]) begin
            send(fr[i]);
            gap($urandom_range(maxgap, 0));
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic build_frame(input int len, input bit bad);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h0;
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        fr.push_back(8'(len >> 8));
        for (int i = 0; i < len * 4; i++) begin
            b = 8'($urandom);
            c ^= b;
            fr.push_back(b);
        end
        if (bad) c ^= 8'($urandom_range(255, 1));
        fr.push_back(c);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},   64'(imem_we), 64'(0));
        check({tag, "_addr"}, 64'(imem_addr), 64'(0));
        check({tag, "_crn"},  64'(core_rst_n), 64'(0));
        check({tag, "_done"}, 64'(load_done), 64'(0));
        check({tag, "_err"},  64'({load_err, err_code}), 64'(0));
    endtask

    int n0;

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_wdata", 64'(imem_wdata), 64'(0));
        rst = 1'b0;
        gap(2);

        // Nominal two-word frame, back to back.
        n0 = wlog.size();
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        send_fr(0);
        gap(1);
        check("a_nwr", 64'(wlog.size() - n0), 64'(2));
        if (wlog.size() >= n0 + 2) begin
            check("a_w0", 64'(wlog[n0]), {32'h0, 32'h00100513});
            check("a_w1", 64'(wlog[n0+1]), {32'h4, 32'h00200593});
        end
        check("a_model_chk", 64'(m_chk), 64'(8'hB0));
        check("a_done", 64'({load_done, core_rst_n, load_err, err_code}), 64'(5'b11000));

        // Bytes ignored in DONE, then reload.
        send(8'hA5);
        send(8'h00);
        check("done_hold", 64'(load_done), 64'(1));
        pulse_reload();
        check("reload_crn", 64'({core_rst_n, load_done}), 64'(0));

        // Bad checksum: words still written, core held.
        n0 = wlog.size();
        fr[11] = 8'hB1;
        send_fr(0);
        gap(1);
        check("b_nwr", 64'(wlog.size() - n0), 64'(2));
        check("b_err", 64'({load_err, err_code, core_rst_n}), 64'(4'b1010));
        fr[11] = 8'hB0;
        send_fr(1);
        gap(1);
        check("b_retry", 64'({load_done, core_rst_n, load_err}), 64'(3'b110));
        pulse_reload();

        // Length over the limit.
        n0 = wlog.size();
        send(8'hA5); send(8'h01); send(8'h04);
        check("len_err", 64'({load_err, err_code}), 64'(3'b110));
        check("len_nwr", 64'(wlog.size() - n0), 64'(0));
        pulse_reload();

        // Timeout after a partial word.
        n0 = wlog.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h05);
        gap(TMO - 1);
        check("tmo_early", 64'(load_err), 64'(0));
        gap(1);
        check("tmo_err", 64'({load_err, err_code}), 64'(3'b111));
        check("tmo_nwr", 64'(wlog.size() - n0), 64'(0));
        pulse_reload();

        // Junk in IDLE, zero-length frame, reload.
        n0 = wlog.size();
        send(8'h00); send(8'hFF);
        pulse_reload();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        check("zero_done", 64'({load_done, core_rst_n}), 64'(2'b11));
        check("zero_nwr", 64'(wlog.size() - n0), 64'(0));
        pulse_reload();
        check("zero_reload", 64'(core_rst_n), 64'(0));

        // reload mid-frame is ignored.
        n0 = wlog.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h05);
        pulse_reload();
        send(8'h10); send(8'h00); send(8'h06);
        check("midreload_done", 64'(load_done), 64'(1));
        check("midreload_nwr", 64'(wlog.size() - n0), 64'(1));
        pulse_reload();

        // rst after the third payload byte: no write.
        n0 = wlog.size();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h05); send(8'h10);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        send(8'h00);
        gap(2);
        check("midrst_nwr", 64'(wlog.size() - n0), 64'(0));

        // Randomized frames.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(3, 0) != 0) pulse_reload();
            if ($urandom_range(3, 0) == 0) begin
                send(8'($urandom_range(8'hA4, 0)));
                gap($urandom_range(2, 0));
            end
            build_frame($urandom_range(5, 0), $urandom_range(3, 0) == 0);
            if ($urandom_range(7, 0) == 0) begin
                void'(fr.pop_back());
                send_fr(3);
                gap(TMO + 2);
            end else begin
                send_fr($urandom_range(3, 0));
            end
            gap($urandom_range(3, 0));
        end

        // Unstructured random traffic.
        for (int c = 0; c < 3000; c++) begin
            rx_valid = 1'($urandom);
            rx_data  = ($urandom_range(7, 0) == 0) ? 8'hA5 : 8'($urandom);
            reload   = ($urandom_range(15, 0) == 0);
            rst      = ($urandom_range(299, 0) == 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        reload   = 1'b0;
        rst      = 1'b0;
        gap(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
